mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the processing element's single local memory port between the CPU and the DDMA engine.
- Sits between `interface_cpu` / `ddma` and `interface_memory`.
- Arbitration: round-robin per beat, with an optional requester lock for bursts, bounded by a starvation limit.
- The memory command is registered, so the arbiter adds one pipeline stage. Read data returns tagged to the requester that issued it.

Parameters:
- MEMORY_BUS_WIDTH, 32, data width of the memory port and both requesters.
- ADDR_WIDTH, 32, address width.
- MAX_BURST, 16, maximum consecutive grants to one requester while the other is waiting. Legal range 1..255.

Ports:
- clock in 1: system clock, all logic on the rising edge.
- reset in 1: synchronous, active-high.
- cpu_req in 1: CPU beat request.
- cpu_we in 1: 1 = write, 0 = read.
- cpu_lock in 1: keep ownership for the next beat.
- cpu_addr in ADDR_WIDTH: beat address.
- cpu_wdata in MEMORY_BUS_WIDTH: write data.
- cpu_gnt out 1: beat accepted this cycle.
- cpu_rvalid out 1: read data valid.
- cpu_rdata out MEMORY_BUS_WIDTH: read data.
- dma_req, dma_we, dma_lock, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same as cpu_*, for the DDMA.
- mem_en out 1: memory access strobe.
- mem_we out 1: memory write enable.
- mem_addr out ADDR_WIDTH: memory address.
- mem_wdata out MEMORY_BUS_WIDTH: memory write data.
- mem_rdata in MEMORY_BUS_WIDTH: memory read data, valid exactly 1 cycle after mem_en with mem_we=0.

Behaviour:
- Clock and reset: single clock `clock`; reset `reset` is synchronous, active-high.
- Reset values:
  - All outputs 0.
  - State = IDLE, burst_cnt = 0, rr_last = DMA, so the CPU wins the first tie.
  - In-flight read tag cleared.
- Beat handshake:
  - A beat is accepted in cycle N when req=1 and gnt=1.
  - gnt is combinational from req, state, rr_last and burst_cnt.
  - At most one gnt per cycle; cpu_gnt and dma_gnt are never both 1.
  - A requester holds req/we/addr/wdata stable until granted.
- Memory pipeline:
  - The accepted beat is registered and drives mem_en=1, mem_we, mem_addr and mem_wdata in cycle N+1.
  - mem_en=0 in any cycle following a cycle with no grant.
- Read return:
  - A read accepted at N gives owner rvalid=1 at N+2, with owner rdata = mem_rdata.
  - Writes produce no rvalid.
  - The non-owner's rdata is driven 0.
  - Back-to-back reads from alternating requesters return in issue order, one per cycle.
- FSM states: IDLE, CPU_OWN, DMA_OWN. The state records the owner of the last granted beat.
- Grant decision in IDLE, or when the owner dropped req:
  - Only one requester: grant it.
  - Both requesters: grant the one that is not rr_last.
  - Neither: no grant; next state IDLE, burst_cnt = 0.
- Grant decision in X_OWN with both requesting:
  - X keeps the grant if X_lock=1 and burst_cnt < MAX_BURST.
  - Otherwise the grant goes to the other requester.
  - Without lock, both-requesting traffic strictly alternates per beat.
- Grant decision in X_OWN with only X requesting: X is granted regardless of lock or burst_cnt.
- burst_cnt bookkeeping:
  - On a grant to the same owner: burst_cnt increments, saturating at MAX_BURST.
  - On a grant to a new owner: burst_cnt = 1, and rr_last is set to the new owner.
- Starvation bound: the waiting requester is granted no later than MAX_BURST cycles after it raises req, even if the owner holds lock continuously.
- Reset mid-operation:
  - A pending registered command is discarded: mem_en=0 in the cycle after reset is sampled.
  - An outstanding read returns no rvalid.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, the block adds output ports:
  - stat_cpu_wait out 32: cycles with cpu_req=1 and cpu_gnt=0.
  - stat_dma_wait out 32: same for dma.
  - stat_forced out 16: number of switches forced by the MAX_BURST limit while the owner's lock was 1.
- All counters are 0 on reset and saturate at their maximum value.
- When not defined, these ports and counters do not exist and the behaviour is otherwise identical.

Test Plan:
- Reset check: hold reset 3 cycles with random inputs -> all outputs 0. First cycle after reset with both req=1 -> cpu_gnt=1.
- CPU single read: read addr 0x40 accepted at cycle 10 -> mem_en=1, mem_we=0, mem_addr=0x40 at cycle 11; memory returns 0xDEADBEEF -> cpu_rvalid=1, cpu_rdata=0xDEADBEEF at cycle 12; dma_rvalid stays 0.
- Round-robin: both requesting continuously, no lock -> grant order C, D, C, D for 8 beats; rvalid returns to the matching requester in the same order.
- Starvation bound: MAX_BURST=4, DMA lock=1 holding ownership, CPU req raised -> DMA gets exactly 4 consecutive grants (burst_cnt reaches 4), then cpu_gnt=1; stat_forced=1 when MEM_ARB_STATS_EN is defined.
- Reset during read: DMA read accepted at cycle N, reset=1 at N+1 -> mem_en=0 at N+2, no dma_rvalid ever asserted; the next grant favours the CPU.
- Write-only burst: DMA writes 3 beats to addresses 0x0, 0x4, 0x8 with no CPU activity -> mem_we=1 for three consecutive cycles with matching addr/wdata; no rvalid on either side.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter sharing one local memory port between
// the CPU and the DDMA engine. Round-robin per beat, optional per-requester
// lock for bursts, bounded by MAX_BURST. The memory command is registered
// (one pipeline stage); read data is returned to the requester that issued it.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   cpu_*/dma_*             requester side: req, we, lock, addr, wdata in;
//                           gnt, rvalid, rdata out
//   mem_en/we/addr/wdata    registered memory command
//   mem_rdata               memory read data, valid 1 cycle after a read strobe
//   stat_cpu_wait/stat_dma_wait/stat_forced
//                           optional saturating counters, present only when
//                           MEM_ARB_STATS_EN is defined
//
// state   | meaning
// IDLE    | no beat granted last cycle
// CPU_OWN | last granted beat belonged to the CPU
// DMA_OWN | last granted beat belonged to the DDMA

module mem_arbiter #(
   parameter int MEMORY_BUS_WIDTH = 32,
   parameter int ADDR_WIDTH       = 32,
   parameter int MAX_BURST        = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        cpu_req,
   input  logic                        cpu_we,
   input  logic                        cpu_lock,
   input  logic [ADDR_WIDTH-1:0]       cpu_addr,
   input  logic [MEMORY_BUS_WIDTH-1:0] cpu_wdata,
   output logic                        cpu_gnt,
   output logic                        cpu_rvalid,
   output logic [MEMORY_BUS_WIDTH-1:0] cpu_rdata,
   input  logic                        dma_req,
   input  logic                        dma_we,
   input  logic                        dma_lock,
   input  logic [ADDR_WIDTH-1:0]       dma_addr,
   input  logic [MEMORY_BUS_WIDTH-1:0] dma_wdata,
   output logic                        dma_gnt,
   output logic                        dma_rvalid,
   output logic [MEMORY_BUS_WIDTH-1:0] dma_rdata,
   output logic                        mem_en,
   output logic                        mem_we,
   output logic [ADDR_WIDTH-1:0]       mem_addr,
   output logic [MEMORY_BUS_WIDTH-1:0] mem_wdata,
`ifdef MEM_ARB_STATS_EN
   output logic [31:0]                 stat_cpu_wait,
   output logic [31:0]                 stat_dma_wait,
   output logic [15:0]                 stat_forced,
`endif
   input  logic [MEMORY_BUS_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, CPU_OWN, DMA_OWN} state_t;

   localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

   state_t     state;
   logic [7:0] burst_cnt;
   logic       rr_last_dma;
   logic       grant_cpu;
   logic       grant_dma;
   logic       cmd_dma;
   logic       rd_pend;
   logic       rd_dma;

   // Reset gates the grant so no beat is accepted while reset is asserted.
   always_comb begin
      grant_cpu = 1'b0;
      grant_dma = 1'b0;
      if (!reset) begin
         if (state == CPU_OWN && cpu_req) begin
            if (dma_req && !(cpu_lock && burst_cnt < BURST_MAX)) grant_dma = 1'b1;
            else                                                grant_cpu = 1'b1;
         end else if (state == DMA_OWN && dma_req) begin
            if (cpu_req && !(dma_lock && burst_cnt < BURST_MAX)) grant_cpu = 1'b1;
            else                                                grant_dma = 1'b1;
         end else if (cpu_req && dma_req) begin
            grant_cpu = rr_last_dma;
            grant_dma = !rr_last_dma;
         end else begin
            grant_cpu = cpu_req;
            grant_dma = dma_req;
         end
      end
   end

   assign cpu_gnt = grant_cpu;
   assign dma_gnt = grant_dma;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         burst_cnt   <= 8'd0;
         rr_last_dma <= 1'b1;
      end else if (grant_cpu) begin
         if (state == CPU_OWN) begin
            if (burst_cnt < BURST_MAX) burst_cnt <= burst_cnt + 8'd1;
         end else begin
            burst_cnt   <= 8'd1;
            rr_last_dma <= 1'b0;
         end
         state <= CPU_OWN;
      end else if (grant_dma) begin
         if (state == DMA_OWN) begin
            if (burst_cnt < BURST_MAX) burst_cnt <= burst_cnt + 8'd1;
         end else begin
            burst_cnt   <= 8'd1;
            rr_last_dma <= 1'b1;
         end
         state <= DMA_OWN;
      end else begin
         state     <= IDLE;
         burst_cnt <= 8'd0;
      end
   end

   // Command register plus the one-cycle read tag that follows a read strobe.
   always_ff @(posedge clock) begin
      if (reset) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cmd_dma   <= 1'b0;
         rd_pend   <= 1'b0;
         rd_dma    <= 1'b0;
      end else begin
         mem_en <= grant_cpu | grant_dma;
         mem_we <= (grant_cpu & cpu_we) | (grant_dma & dma_we);
         if (grant_cpu) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            cmd_dma   <= 1'b0;
         end else if (grant_dma) begin
            mem_addr  <= dma_addr;
            mem_wdata <= dma_wdata;
            cmd_dma   <= 1'b1;
         end
         rd_pend <= mem_en & ~mem_we;
         rd_dma  <= cmd_dma;
      end
   end

   assign cpu_rvalid = rd_pend & ~rd_dma;
   assign dma_rvalid = rd_pend & rd_dma;
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
   assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

`ifdef MEM_ARB_STATS_EN
   logic forced;

   // A switch forced by the burst limit: both requesting, owner locked, limit hit.
   assign forced = cpu_req && dma_req && burst_cnt >= BURST_MAX &&
                   ((state == CPU_OWN && cpu_lock) || (state == DMA_OWN && dma_lock));

   always_ff @(posedge clock) begin
      if (reset) begin
         stat_cpu_wait <= '0;
         stat_dma_wait <= '0;
         stat_forced   <= '0;
      end else begin
         if (cpu_req && !grant_cpu && stat_cpu_wait != '1) stat_cpu_wait <= stat_cpu_wait + 32'd1;
         if (dma_req && !grant_dma && stat_dma_wait != '1) stat_dma_wait <= stat_dma_wait + 32'd1;
         if (forced && stat_forced != '1)                  stat_forced   <= stat_forced + 16'd1;
      end
   end
`endif

endmodule
